// File: rtl/svm_stream_pkg.sv
// Shared types for the SVM feature-vector stream receiver: write FSM states and
// per-bank status for the ping-pong frame buffer.
package svm_stream_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic             full;
    logic [LEN_W-1:0] len;
  } bank_stat_t;

endpackage

// File: rtl/svm_bank_ram.sv
// Two-bank frame store addressed as {bank, index}: one write port and one
// registered read port feeding the kernel datapath.
module svm_bank_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/svm_x_stream_rx.sv
// Framed feature-vector receiver: write FSM fills alternating banks, commits are
// presented to the consumer in FIFO order, framing errors are pulsed.
module svm_x_stream_rx
  import svm_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] input_x,
  input  logic              sop_x,
  input  logic              valid_x,
  input  logic              eop_x,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  input  logic              frame_done,
  output logic              err_sop,
  output logic              err_orphan,
  output logic              err_len,
  output logic              err_ovf,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);

  rx_state_t         state, state_nxt;
  logic              wr_bank, rd_bank;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  bank_stat_t        bank_stat [2];
  logic              pend, pend_bank;
  logic [ADDR_W:0]   pend_len;
  logic              we, commit, bank_free, release_bank;
  logic [ADDR_W-1:0] wr_idx;
  logic              sop_e, orph_e, len_e, ovf_e;

  assign bank_free    = !bank_stat[wr_bank].full;
  assign frame_valid  = bank_stat[rd_bank].full;
  assign frame_len    = frame_valid ? (ADDR_W+1)'(bank_stat[rd_bank].len) : '0;
  assign release_bank = frame_done && frame_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    wr_idx    = cnt[ADDR_W-1:0];
    commit    = 1'b0;
    sop_e     = 1'b0;
    orph_e    = 1'b0;
    len_e     = 1'b0;
    ovf_e     = 1'b0;
    case (state)
      ST_IDLE, ST_DROP: begin
        if (valid_x) begin
          if (sop_x) begin
            if (bank_free) begin
              we        = 1'b1;
              wr_idx    = '0;
              cnt_nxt   = 1;
              commit    = eop_x;
              state_nxt = eop_x ? ST_IDLE : ST_RECV;
            end else begin
              ovf_e     = 1'b1;
              state_nxt = eop_x ? ST_IDLE : ST_DROP;
            end
          end else if (state == ST_IDLE) begin
            orph_e = 1'b1;
          end else if (eop_x) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_RECV: begin
        if (valid_x) begin
          // A fresh sop restarts the frame in the same bank; the bank is known free.
          if (sop_x) begin
            sop_e     = 1'b1;
            we        = 1'b1;
            wr_idx    = '0;
            cnt_nxt   = 1;
            commit    = eop_x;
            state_nxt = eop_x ? ST_IDLE : ST_RECV;
          end else if (cnt == MAX_CNT) begin
            len_e     = 1'b1;
            state_nxt = eop_x ? ST_IDLE : ST_DROP;
          end else begin
            we        = 1'b1;
            cnt_nxt   = cnt + 1'b1;
            commit    = eop_x;
            state_nxt = eop_x ? ST_IDLE : ST_RECV;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Commits are staged one cycle so the bank turns full the edge after eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wr_bank    <= 1'b0;
      pend       <= 1'b0;
      pend_bank  <= 1'b0;
      pend_len   <= '0;
      err_sop    <= 1'b0;
      err_orphan <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend       <= commit;
      err_sop    <= sop_e;
      err_orphan <= orph_e;
      err_len    <= len_e;
      err_ovf    <= ovf_e;
      if (commit) begin
        pend_bank <= wr_bank;
        pend_len  <= cnt_nxt;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_stat[0] <= '0;
      bank_stat[1] <= '0;
      rd_bank      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (pend) begin
        bank_stat[pend_bank] <= '{full: 1'b1, len: LEN_W'(pend_len)};
        frame_cnt            <= frame_cnt + 16'd1;
      end
      if (release_bank) begin
        bank_stat[rd_bank].full <= 1'b0;
        rd_bank                 <= ~rd_bank;
      end
    end
  end

  svm_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (input_x),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_svm_x_stream_rx.sv
// Scoreboard bench for svm_x_stream_rx: frames pushed when driven, popped and
// compared as the receiver presents them.
module tb_svm_x_stream_rx;

  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] input_x = '0;
  logic              sop_x = 1'b0;
  logic              valid_x = 1'b0;
  logic              eop_x = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              frame_valid;
  logic [ADDR_W:0]   frame_len;
  logic              frame_done = 1'b0;
  logic              err_sop, err_orphan, err_len, err_ovf;
  logic [15:0]       frame_cnt;

  int compared = 0;
  int mismatched = 0;
  int n_sop = 0, n_orph = 0, n_len = 0, n_ovf = 0;

  logic [DATA_W-1:0] word_q [$];
  int                len_q  [$];

  svm_x_stream_rx #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_x     (input_x),
    .sop_x       (sop_x),
    .valid_x     (valid_x),
    .eop_x       (eop_x),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_done  (frame_done),
    .err_sop     (err_sop),
    .err_orphan  (err_orphan),
    .err_len     (err_len),
    .err_ovf     (err_ovf),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_sop)    n_sop++;
      if (err_orphan) n_orph++;
      if (err_len)    n_len++;
      if (err_ovf)    n_ovf++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_word(input logic [DATA_W-1:0] d, input logic s, input logic e);
    @(negedge clk);
    input_x = d;
    sop_x   = s;
    eop_x   = e;
    valid_x = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_x = 1'b0;
    sop_x   = 1'b0;
    eop_x   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [DATA_W-1:0] base, input bit expect_commit);
    for (int i = 0; i < n; i++) begin
      send_word(base + DATA_W'(i), i == 0, i == n - 1);
      if (expect_commit) word_q.push_back(base + DATA_W'(i));
    end
    if (expect_commit) len_q.push_back(n);
  endtask

  task automatic check_presented(input string name);
    bit ok;
    int exp_len;
    logic [ADDR_W:0] exp_len_v;
    logic [DATA_W-1:0] exp_word;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (frame_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s_wait: frame_valid=%b, required 1 within 20 cycles", name, frame_valid);
    end
    if (len_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_sb: presented frame but scoreboard empty", name);
      return;
    end
    exp_len   = len_q.pop_front();
    exp_len_v = (ADDR_W+1)'(exp_len);
    compared++;
    if (frame_len !== exp_len_v) begin
      mismatched++;
      $display("[TB] FAIL %s_len: got %0d, required %0d", name, frame_len, exp_len_v);
    end
    for (int i = 0; i < exp_len; i++) begin
      @(negedge clk);
      rd_addr = ADDR_W'(i);
      @(negedge clk);
      exp_word = word_q.pop_front();
      compared++;
      if (rd_data !== exp_word) begin
        mismatched++;
        $display("[TB] FAIL %s_data[%0d]: got 0x%08h, required 0x%08h", name, i, rd_data, exp_word);
      end
    end
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    compared++;
    if (frame_cnt !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({frame_valid, frame_len} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_frame: valid=%b len=%0d, required 0/0", frame_valid, frame_len);
    end
    compared++;
    if ({err_sop, err_orphan, err_len, err_ovf} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_err: got %b, required 0000", {err_sop, err_orphan, err_len, err_ovf});
    end
    compared++;
    if (rd_data !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_rd_data: got 0x%08h, required 0", rd_data);
    end
    check_cnt("reset", 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e0;
    e0 = n_sop + n_orph + n_len + n_ovf;
    send_frame(4, 32'h1, 1'b1);
    idle_cycle();
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_early_valid: got %b, required 0", frame_valid);
    end
    @(negedge clk);
    compared++;
    if (frame_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_commit_valid: got %b, required 1", frame_valid);
    end
    check_presented("basic");
    check_cnt("basic", 16'd1);
    compared++;
    if (n_sop + n_orph + n_len + n_ovf - e0 !== 0) begin
      mismatched++;
      $display("[TB] FAIL basic_errs: got %0d pulses, required 0", n_sop + n_orph + n_len + n_ovf - e0);
    end
  endtask

  task automatic test_back_to_back();
    int ovf0, e0;
    ovf0 = n_ovf;
    e0   = n_sop + n_orph + n_len + n_ovf;
    send_frame(2, 32'h10, 1'b1);
    send_frame(2, 32'h20, 1'b1);
    send_frame(2, 32'h30, 1'b0);
    idle_cycle();
    idle_cycle();
    compared++;
    if (n_ovf - ovf0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_ovf: got %0d pulses, required 1", n_ovf - ovf0);
    end
    compared++;
    if (n_sop + n_orph + n_len + n_ovf - e0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_errs: got %0d pulses, required 1", n_sop + n_orph + n_len + n_ovf - e0);
    end
    check_cnt("b2b", 16'd3);
    check_presented("b2b_first");
    check_presented("b2b_second");
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drained: frame_valid=%b, required 0", frame_valid);
    end
  endtask

  task automatic test_single();
    send_word(32'hABCD, 1'b1, 1'b1);
    word_q.push_back(32'hABCD);
    len_q.push_back(1);
    idle_cycle();
    check_presented("single");
    check_cnt("single", 16'd4);
  endtask

  task automatic test_err_sop();
    int s0;
    s0 = n_sop;
    send_word(32'h51, 1'b1, 1'b0);
    send_word(32'h52, 1'b0, 1'b0);
    send_word(32'h53, 1'b0, 1'b0);
    send_frame(2, 32'h61, 1'b1);
    idle_cycle();
    idle_cycle();
    compared++;
    if (n_sop - s0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL errsop_pulse: got %0d pulses, required 1", n_sop - s0);
    end
    check_presented("errsop");
    check_cnt("errsop", 16'd5);
  endtask

  task automatic test_err_len();
    int l0, o0, e0;
    send_frame(MAX_LEN, 32'hA0, 1'b1);
    idle_cycle();
    check_presented("maxlen");
    check_cnt("maxlen", 16'd6);
    l0 = n_len;
    o0 = n_orph;
    e0 = n_sop + n_orph + n_len + n_ovf;
    for (int i = 0; i < MAX_LEN + 2; i++)
      send_word(32'hB0 + DATA_W'(i), i == 0, i == MAX_LEN + 1);
    repeat (3) idle_cycle();
    compared++;
    if (n_len - l0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL errlen_pulse: got %0d pulses, required 1", n_len - l0);
    end
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL errlen_nocommit: frame_valid=%b, required 0", frame_valid);
    end
    check_cnt("errlen", 16'd6);
    send_word(32'hC0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    compared++;
    if (n_orph - o0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL orphan_pulse: got %0d pulses, required 1", n_orph - o0);
    end
    compared++;
    if (n_sop + n_orph + n_len + n_ovf - e0 !== 2) begin
      mismatched++;
      $display("[TB] FAIL errlen_errs: got %0d pulses, required 2", n_sop + n_orph + n_len + n_ovf - e0);
    end
    send_frame(3, 32'hD0, 1'b1);
    idle_cycle();
    check_presented("after_err");
    check_cnt("after_err", 16'd7);
  endtask

  task automatic test_reset_mid();
    send_frame(2, 32'h70, 1'b1);
    idle_cycle();
    idle_cycle();
    send_word(32'h80, 1'b1, 1'b0);
    send_word(32'h81, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_valid: got %b, required 0", frame_valid);
    end
    check_cnt("midreset", 16'd0);
    word_q.delete();
    len_q.delete();
    valid_x = 1'b0;
    sop_x   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    send_frame(3, 32'h90, 1'b1);
    idle_cycle();
    check_presented("postreset");
    check_cnt("postreset", 16'd1);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_back_to_back();
    test_single();
    test_err_sop();
    test_err_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
